regfile_dbg_port: RTL
=====================

Name: regfile_dbg_port

Overview:
- Debug-side initiator for the 3-port register file (32 x 32-bit; r0 reads zero; combinational reads).
- Accepts read, write and dump commands from the debug host over a valid/ready command channel.
- Sequences the register-file ports and returns the results on a valid/ready response channel.
- Owns the register-file port mux, via dbg_active, only while the CPU is halted.

Parameters:
- WIDTH, 32, data width of registers, wd3 and responses.
- NREGS, 32, number of registers swept by a dump; addresses 0..NREGS-1; must be at most 32.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_halted  in  1  CPU halted; commands are accepted only while this is 1.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  00=read, 01=write, 10=dump, 11=reserved.
- cmd_addr  in  5  register index for read/write; ignored for dump.
- cmd_data  in  WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  host accepts response.
- rsp_data  out  WIDTH  read data, or 0 for write/error.
- rsp_addr  out  5  register index the response refers to.
- rsp_last  out  1  final response of a command.
- rsp_err  out  1  reserved opcode.
- dbg_active  out  1  selects debug drivers onto register-file ports.
- dbg_we3  out  1  write enable to register file.
- dbg_wa3  out  5  write address.
- dbg_wd3  out  WIDTH  write data.
- dbg_ra1  out  5  read address.
- rf_rd1  in  WIDTH  register-file read data, port 1.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values: state=IDLE, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_last=0, rsp_err=0, dbg_active=0, dbg_we3=0, dbg_ra1=0, dbg_wa3=0, dbg_wd3=0, dump index=0.
- Reset mid-command aborts it: no write is issued after the reset edge, and any pending response is dropped.
- States: IDLE, WR, RD, RESP, DUMP_RD, DUMP_RESP.
- IDLE: cmd_ready = cpu_halted. A command is accepted on a cycle where cmd_valid && cmd_ready. op, addr and data are latched on acceptance.
- Transitions from IDLE on acceptance:
  - read -> RD
  - write -> WR
  - dump -> DUMP_RD, with index=0
  - reserved -> RESP, with rsp_err=1, rsp_data=0, rsp_addr=cmd_addr, rsp_last=1; no register-file access.
- cmd_ready=0 in every state except IDLE.
- dbg_active=1 in WR, RD and DUMP_RD. It is also 1 in RESP and DUMP_RESP when reached from those states. It drops to 0 in the cycle the block returns to IDLE.
- WR (1 cycle):
  - Drives dbg_we3=1, dbg_wa3=addr, dbg_wd3=data.
  - addr==0: dbg_we3 stays 0.
  - Next state RESP with rsp_data=0, rsp_addr=addr, rsp_last=1, rsp_err=0.
- RD and DUMP_RD (1 cycle each):
  - Drives dbg_ra1 = address (addr or index), dbg_we3=0, dbg_wd3=0.
  - The register file forwards wd3 whenever ra1==wa3, regardless of we3. Therefore dbg_wa3 must equal ~dbg_ra1 in every non-write cycle.
  - rf_rd1 is registered into rsp_data at the end of the cycle; rsp_addr=address.
  - RD -> RESP with rsp_last=1. DUMP_RD -> DUMP_RESP with rsp_last=(index==NREGS-1).
- Read latency: command acceptance to rsp_valid is 2 cycles.
- RESP and DUMP_RESP: rsp_valid=1. rsp_data, rsp_addr, rsp_last and rsp_err are held stable until rsp_valid && rsp_ready.
  - RESP on handshake -> IDLE.
  - DUMP_RESP on handshake: if rsp_last -> IDLE; else index+1 -> DUMP_RD.
- Dump back-pressure: with rsp_ready held high, one response every 2 cycles.
- Regfile ports in the response states: dbg_we3=0 whenever the state is not WR. The read address is held.
- cpu_halted is sampled only in IDLE. Deassertion during a command does not abort it; the command completes, including a full dump.
- No new command is accepted until the final response handshake completes, so the block has at most one command in flight.
- Index counter is 5 bits and never wraps past NREGS-1.

Test Plan:
- Reset, then cpu_halted=1, write r5=0xDEADBEEF -> exactly 1 cycle with dbg_we3=1, wa3=5, wd3=0xDEADBEEF; response rsp_addr=5, rsp_last=1, rsp_err=0.
- Read r5 with the register-file model holding 0xDEADBEEF -> rsp_valid 2 cycles after acceptance, rsp_data=0xDEADBEEF; dbg_wa3 != dbg_ra1 in the RD cycle.
- Write r0=0x12345678, then read r0 -> dbg_we3 never asserts; the read returns 0x00000000.
- Dump with rf[i]=i*0x11 and rsp_ready toggling randomly -> 32 responses in order, addr 0..31, data i*0x11, rsp_last only on addr 31, each response held stable while stalled.
- cpu_halted=0 with cmd_valid=1 -> cmd_ready=0, no activity. Drop cpu_halted mid-dump -> the dump still completes all 32 responses.
- Reserved op 11 -> single response with rsp_err=1, rsp_data=0, no dbg_we3. Reset asserted during DUMP_RD of index 7 -> next cycle all outputs at reset values, no further responses.

Source files
------------

// File: rtl/regfile_dbg_port.sv
// Debug-side initiator for the 3-port register file: runs read, write and dump
// commands from the debug host and drives the register-file port mux while the CPU is halted.
module regfile_dbg_port #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 32,
  localparam int unsigned AW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_halted,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [AW-1:0]    rsp_addr,
  output logic             rsp_last,
  output logic             rsp_err,
  output logic             dbg_active,
  output logic             dbg_we3,
  output logic [AW-1:0]    dbg_wa3,
  output logic [WIDTH-1:0] dbg_wd3,
  output logic [AW-1:0]    dbg_ra1,
  input  logic [WIDTH-1:0] rf_rd1
);

  localparam logic [1:0]    OP_RD    = 2'b00;
  localparam logic [1:0]    OP_WR    = 2'b01;
  localparam logic [1:0]    OP_DUMP  = 2'b10;
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic [2:0] {
    IDLE, WR, RD, RESP, DUMP_RD, DUMP_RESP
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]    idx, idx_d;
  logic             rsp_valid_d, rsp_last_d, rsp_err_d;
  logic [WIDTH-1:0] rsp_data_d;
  logic [AW-1:0]    rsp_addr_d;
  logic             active_d, we3_d;
  logic [AW-1:0]    wa3_d, ra1_d;
  logic [WIDTH-1:0] wd3_d;

  logic cmd_accept, rsp_fire;

  // Commands only enter from IDLE while halted; held low during reset
  assign cmd_ready  = (state == IDLE) && cpu_halted && !reset;
  assign cmd_accept = cmd_valid && cmd_ready;
  assign rsp_fire   = rsp_valid && rsp_ready;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_addr   <= '0;
      rsp_last   <= 1'b0;
      rsp_err    <= 1'b0;
      dbg_active <= 1'b0;
      dbg_we3    <= 1'b0;
      dbg_wa3    <= '0;
      dbg_wd3    <= '0;
      dbg_ra1    <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_d;
      rsp_valid  <= rsp_valid_d;
      rsp_data   <= rsp_data_d;
      rsp_addr   <= rsp_addr_d;
      rsp_last   <= rsp_last_d;
      rsp_err    <= rsp_err_d;
      dbg_active <= active_d;
      dbg_we3    <= we3_d;
      dbg_wa3    <= wa3_d;
      dbg_wd3    <= wd3_d;
      dbg_ra1    <= ra1_d;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (cmd_accept) begin
          unique case (cmd_op)
            OP_RD:   state_nxt = RD;
            OP_WR:   state_nxt = WR;
            OP_DUMP: state_nxt = DUMP_RD;
            default: state_nxt = RESP;
          endcase
        end
      end
      WR, RD:    state_nxt = RESP;
      DUMP_RD:   state_nxt = DUMP_RESP;
      RESP:      if (rsp_fire) state_nxt = IDLE;
      DUMP_RESP: if (rsp_fire) state_nxt = rsp_last ? IDLE : DUMP_RD;
      default:   state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the state being entered
  always_comb begin
    idx_d       = idx;
    rsp_data_d  = rsp_data;
    rsp_addr_d  = rsp_addr;
    rsp_last_d  = rsp_last;
    rsp_err_d   = rsp_err;
    ra1_d       = dbg_ra1;
    we3_d       = 1'b0;
    wd3_d       = '0;
    rsp_valid_d = (state_nxt == RESP) || (state_nxt == DUMP_RESP);
    // Reserved op answers straight from IDLE without taking the mux
    active_d    = (state_nxt != IDLE) && !((state == IDLE) && (state_nxt == RESP));

    if ((state == IDLE) && cmd_accept) idx_d = '0;
    if ((state == DUMP_RESP) && rsp_fire && !rsp_last) idx_d = idx + AW'(1);

    unique case (state_nxt)
      WR: begin
        we3_d = (cmd_addr != '0);
        wd3_d = cmd_data;
      end
      RD:      ra1_d = cmd_addr;
      DUMP_RD: ra1_d = idx_d;
      default: ;
    endcase

    // Keep wa3 away from ra1 so the file's wd3 forwarding never hits a read
    wa3_d = (state_nxt == WR) ? cmd_addr : ~ra1_d;

    unique case (state)
      IDLE: begin
        if (state_nxt == RESP) begin
          rsp_data_d = '0;
          rsp_addr_d = cmd_addr;
          rsp_last_d = 1'b1;
          rsp_err_d  = 1'b1;
        end
      end
      WR: begin
        rsp_data_d = '0;
        rsp_addr_d = dbg_wa3;
        rsp_last_d = 1'b1;
        rsp_err_d  = 1'b0;
      end
      RD: begin
        rsp_data_d = rf_rd1;
        rsp_addr_d = dbg_ra1;
        rsp_last_d = 1'b1;
        rsp_err_d  = 1'b0;
      end
      DUMP_RD: begin
        rsp_data_d = rf_rd1;
        rsp_addr_d = dbg_ra1;
        rsp_last_d = (idx == LAST_IDX);
        rsp_err_d  = 1'b0;
      end
      default: ;
    endcase
  end

endmodule
